// File: rtl/move_button_conditioner.sv
// Button conditioner for the reversi cursor: sync, debounce, press one-shot,
// optional hold auto-repeat, and a priority-encoded one-hot move pulse.
module move_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    output logic       moveRightEn,
    output logic       moveLeftEn,
    output logic       moveUpEn,
    output logic       moveDownEn,
    output logic [3:0] keyHeld
);

    localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rpt_state_e;

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    key_s;
    logic [3:0]    held_q, held_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    rpt_state_e    state_q [4];
    rpt_state_e    state_d [4];
    logic [TW-1:0] tmr_q [4];
    logic [TW-1:0] tmr_d [4];
    logic [3:0]    req;
    logic [3:0]    move_q, move_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            held_q  <= '0;
            move_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]   <= '0;
                tmr_q[i]   <= '0;
                state_q[i] <= ST_IDLE;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            held_q  <= held_d;
            move_q  <= move_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]   <= cnt_d[i];
                tmr_q[i]   <= tmr_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    // Synchroniser output is inverted so 1 means pressed from here on.
    assign key_s = ~sync2_q;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        held_d  = held_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (key_s[i] != held_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    held_d[i] = key_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        req = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            tmr_d[i]   = tmr_q[i];
            if (!held_q[i]) begin
                state_d[i] = ST_IDLE;
                tmr_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    ST_IDLE: begin
                        req[i]     = 1'b1;
                        tmr_d[i]   = '0;
                        state_d[i] = ST_DELAY;
                    end
                    ST_DELAY: begin
                        if (!REPEAT_EN) begin
                            tmr_d[i] = '0;
                        end else if (tmr_q[i] == DLY_LAST) begin
                            req[i]     = 1'b1;
                            tmr_d[i]   = '0;
                            state_d[i] = ST_REPEAT;
                        end else begin
                            tmr_d[i] = tmr_q[i] + TW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (tmr_q[i] == PER_LAST) begin
                            req[i]   = 1'b1;
                            tmr_d[i] = '0;
                        end else begin
                            tmr_d[i] = tmr_q[i] + TW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        tmr_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Losing requests are dropped outright; their timers keep running.
    always_comb begin
        move_d = '0;
        if (req[0]) begin
            move_d = 4'b0001;
        end else if (req[1]) begin
            move_d = 4'b0010;
        end else if (req[2]) begin
            move_d = 4'b0100;
        end else if (req[3]) begin
            move_d = 4'b1000;
        end
    end

    assign moveRightEn = move_q[0];
    assign moveLeftEn  = move_q[1];
    assign moveUpEn    = move_q[2];
    assign moveDownEn  = move_q[3];
    assign keyHeld     = held_q;

endmodule

// File: tb/tb_move_button_conditioner.sv
// Scoreboard bench for move_button_conditioner with short debounce/repeat
// timing; a second instance covers the no-repeat configuration.
module tb_move_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] key_n_nr;
    logic       r_en, l_en, u_en, d_en;
    logic       r_nr, l_nr, u_nr, d_nr;
    logic [3:0] kh, kh_nr;
    logic [3:0] mv, mv_nr;

    typedef struct {
        int         cyc;
        logic [3:0] mv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign mv    = {d_en, u_en, l_en, r_en};
    assign mv_nr = {d_nr, u_nr, l_nr, r_nr};

    move_button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN(1'b1),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .moveRightEn(r_en),
        .moveLeftEn(l_en),
        .moveUpEn(u_en),
        .moveDownEn(d_en),
        .keyHeld(kh)
    );

    move_button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN(1'b0),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut_nr (
        .clk(clk),
        .reset(reset),
        .key_n(key_n_nr),
        .moveRightEn(r_nr),
        .moveLeftEn(l_nr),
        .moveUpEn(u_nr),
        .moveDownEn(d_nr),
        .keyHeld(kh_nr)
    );

    function automatic logic [3:0] sb_pop(input int e);
        logic [3:0] v;
        v = 4'b0000;
        if (exp_q.size() > 0 && exp_q[0].cyc == e) begin
            v = exp_q[0].mv;
            void'(exp_q.pop_front());
        end
        return v;
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        key_n    = 4'hF;
        key_n_nr = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mv !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mv got=%b exp=0000", mv);
        end
        checks++;
        if (kh !== 4'b0000) begin
            errors++;
            $display("FAIL reset_kh got=%b exp=0000", kh);
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mv, mv_nr, kh_nr} !== 12'h000) begin
            errors++;
            $display("FAIL reset_idle got=%b exp=0", {mv, mv_nr, kh_nr});
        end
    endtask

    task automatic test_single_press();
        logic [3:0] em, ek;
        exp_q.push_back('{6, 4'b0001});
        key_n = 4'b1110;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk);
            @(negedge clk);
            em = sb_pop(e);
            ek = (e >= 5 && e < 13) ? 4'b0001 : 4'b0000;
            checks++;
            if (mv !== em) begin
                errors++;
                $display("FAIL single_mv e=%0d got=%b exp=%b", e, mv, em);
            end
            checks++;
            if (kh !== ek) begin
                errors++;
                $display("FAIL single_kh e=%0d got=%b exp=%b", e, kh, ek);
            end
            if (e == 7) key_n = 4'hF;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_left got=%0d exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_glitch();
        key_n = 4'b1011;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (mv !== sb_pop(e)) begin
                errors++;
                $display("FAIL glitch_mv e=%0d got=%b exp=0000", e, mv);
            end
            checks++;
            if (kh !== 4'b0000) begin
                errors++;
                $display("FAIL glitch_kh e=%0d got=%b exp=0000", e, kh);
            end
            if (e == 2) key_n = 4'hF;
        end
    endtask

    task automatic test_hold_repeat();
        logic [3:0] em, ek;
        int pulses[7] = '{6, 16, 21, 26, 31, 36, 41};
        foreach (pulses[k]) exp_q.push_back('{pulses[k], 4'b1000});
        key_n = 4'b0111;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk);
            @(negedge clk);
            em = sb_pop(e);
            ek = (e >= 5 && e < 45) ? 4'b1000 : 4'b0000;
            checks++;
            if (mv !== em) begin
                errors++;
                $display("FAIL hold_mv e=%0d got=%b exp=%b", e, mv, em);
            end
            checks++;
            if (kh !== ek) begin
                errors++;
                $display("FAIL hold_kh e=%0d got=%b exp=%b", e, kh, ek);
            end
            if (e == 39) key_n = 4'hF;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_left got=%0d exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        logic [3:0] em, ek;
        exp_q.push_back('{6, 4'b0001});
        key_n = 4'b1100;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk);
            @(negedge clk);
            em = sb_pop(e);
            ek = (e >= 5 && e < 13) ? 4'b0011 : 4'b0000;
            checks++;
            if (mv !== em) begin
                errors++;
                $display("FAIL simul_mv e=%0d got=%b exp=%b", e, mv, em);
            end
            checks++;
            if (kh !== ek) begin
                errors++;
                $display("FAIL simul_kh e=%0d got=%b exp=%b", e, kh, ek);
            end
            if (e == 7) key_n = 4'hF;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL simul_left got=%0d exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] em, ek;
        exp_q.push_back('{6, 4'b0010});
        exp_q.push_back('{19, 4'b0010});
        key_n = 4'b1101;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            em = sb_pop(e);
            ek = ((e >= 5 && e < 12) || (e >= 18 && e < 25)) ? 4'b0010 : 4'b0000;
            checks++;
            if (mv !== em) begin
                errors++;
                $display("FAIL rsthold_mv e=%0d got=%b exp=%b", e, mv, em);
            end
            checks++;
            if (kh !== ek) begin
                errors++;
                $display("FAIL rsthold_kh e=%0d got=%b exp=%b", e, kh, ek);
            end
            if (e == 11) reset = 1'b1;
            if (e == 12) reset = 1'b0;
            if (e == 19) key_n = 4'hF;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rsthold_left got=%0d exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_no_repeat();
        logic [3:0] em, ek;
        exp_q.push_back('{6, 4'b0001});
        key_n_nr = 4'b1110;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk);
            @(negedge clk);
            em = sb_pop(e);
            ek = (e >= 5 && e < 45) ? 4'b0001 : 4'b0000;
            checks++;
            if (mv_nr !== em) begin
                errors++;
                $display("FAIL norep_mv e=%0d got=%b exp=%b", e, mv_nr, em);
            end
            checks++;
            if (kh_nr !== ek) begin
                errors++;
                $display("FAIL norep_kh e=%0d got=%b exp=%b", e, kh_nr, ek);
            end
            if (e == 39) key_n_nr = 4'hF;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL norep_left got=%0d exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_hold_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        test_no_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
